// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
//   Bundle of every non-clock signal between the pipeline stall/flush
//   controller and its environment (datapath, fetch unit, bench).
//
//   There is no valid/ready handshake on this bundle: every input is a level
//   that is sampled on each rising clock edge, and every output is a level
//   that is valid for the whole cycle (stage_stall, stage_flush, pc_stall,
//   exc_redirect and exc_busy are combinational from the current inputs and
//   state; stall_cnt and flush_cnt are registered).
//
//   Modports:
//     master - environment side: drives the requests, observes the controls
//     slave  - controller side: observes the requests, drives the controls
//
//   Signals:
//     stall_req    [STALL_SRC]        per-source stall request
//     stall_stage  [STALL_SRC*IDX_W]  per-source boundary, source i at [i*IDX_W +: IDX_W]
//     fetch_full                      fetch buffer full
//     br_flush_req                    branch mispredict redirect
//     br_stage     [IDX_W]            stage holding the resolving branch
//     br_delayslot                    delay slot in stage d-1 must survive
//     exc_req                         exception / refetch pulse
//     exc_hold                        outstanding memory op, delays the flush
//     cnt_clr                         synchronous counter clear
//     stage_stall  [STAGES]           per-stage hold
//     stage_flush  [STAGES]           per-stage clear to bubble
//     pc_stall                        freeze PC
//     exc_redirect                    one-cycle exception vector load
//     exc_busy                        exception sequence in progress
//     stall_cnt    [CNT_W]            cycles with stage_stall[0] set
//     flush_cnt    [CNT_W]            cycles with any stage_flush bit set
//     dbg_state    [2]                exception FSM state, for observation
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
   parameter int STAGES    = 6,
   parameter int STALL_SRC = 4,
   parameter int IDX_W     = 3,
   parameter int CNT_W     = 16
);
   logic [STALL_SRC-1:0]       stall_req;
   logic [STALL_SRC*IDX_W-1:0] stall_stage;
   logic                       fetch_full;
   logic                       br_flush_req;
   logic [IDX_W-1:0]           br_stage;
   logic                       br_delayslot;
   logic                       exc_req;
   logic                       exc_hold;
   logic                       cnt_clr;
   logic [STAGES-1:0]          stage_stall;
   logic [STAGES-1:0]          stage_flush;
   logic                       pc_stall;
   logic                       exc_redirect;
   logic                       exc_busy;
   logic [CNT_W-1:0]           stall_cnt;
   logic [CNT_W-1:0]           flush_cnt;
   logic [1:0]                 dbg_state;

   modport master (
      output stall_req, stall_stage, fetch_full, br_flush_req, br_stage,
             br_delayslot, exc_req, exc_hold, cnt_clr,
      input  stage_stall, stage_flush, pc_stall, exc_redirect, exc_busy,
             stall_cnt, flush_cnt, dbg_state
   );

   modport slave (
      input  stall_req, stall_stage, fetch_full, br_flush_req, br_stage,
             br_delayslot, exc_req, exc_hold, cnt_clr,
      output stage_stall, stage_flush, pc_stall, exc_redirect, exc_busy,
             stall_cnt, flush_cnt, dbg_state
   );
endinterface

// File: rtl/pipe_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_fsm
//   Stall/flush controller for an in-order pipeline of STAGES registers
//   (index 0 = fetch side, STAGES-1 = write-back side). Merges several stall
//   sources, a branch-redirect flush and an exception sequence
//   (hold -> flush -> refill) into per-stage stall and flush vectors, and
//   keeps saturating performance counters of stalled and flushing cycles.
//
//   Ports:
//     clk  - clock
//     rst  - asynchronous reset, active-high; forces every control output
//            low while asserted and aborts any exception sequence
//     bus  - pipe_ctrl_if.slave, all requests in and controls out
// ---------------------------------------------------------------------------
module pipe_ctrl_fsm #(
   parameter int STAGES    = 6,
   parameter int STALL_SRC = 4,
   parameter int IDX_W     = 3,
   parameter int REFILL    = 2,
   parameter int CNT_W     = 16
) (
   input  logic         clk,
   input  logic         rst,
   pipe_ctrl_if.slave   bus
);

   // Refill counter must hold REFILL itself; keep it at least one bit wide.
   localparam int RF_W = (REFILL > 1) ? $clog2(REFILL + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_FLUSH   = 2'd2,
      ST_RECOVER = 2'd3
   } state_t;

   state_t            state_q,     state_d;
   logic [RF_W-1:0]   refill_q,    refill_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   // Stall merge results
   logic              stall_any;
   logic [IDX_W-1:0]  stall_b;
   logic [STAGES-1:0] merge_stall;
   logic [STAGES-1:0] merge_bubble;

   // Branch flush results
   logic              br_hit;
   logic [STAGES-1:0] br_mask;

   // Unmasked controls (before reset gating)
   logic [STAGES-1:0] stall_o;
   logic [STAGES-1:0] flush_o;
   logic              pc_stall_o;
   logic              redirect_o;

   // -------------------------------------------------------------------------
   // Stall merge: deepest boundary B over all active sources. Every stage up
   // to and including B holds; the stage just past B gets a bubble so the
   // instruction that moves on is not duplicated.
   // -------------------------------------------------------------------------
   always_comb begin
      stall_any    = 1'b0;
      stall_b      = '0;
      merge_stall  = '0;
      merge_bubble = '0;
      for (int i = 0; i < STALL_SRC; i++) begin
         if (bus.stall_req[i]) begin
            stall_any = 1'b1;
            if (bus.stall_stage[i*IDX_W +: IDX_W] > stall_b) begin
               stall_b = bus.stall_stage[i*IDX_W +: IDX_W];
            end
         end
      end
      for (int k = 0; k < STAGES; k++) begin
         merge_stall[k]  = stall_any && (k <= int'(stall_b));
         merge_bubble[k] = stall_any && (k == int'(stall_b) + 1);
      end
   end

   // -------------------------------------------------------------------------
   // Branch flush: kills every stage younger than the branch (or younger than
   // the delay slot). If a stall currently holds the branch stage the redirect
   // cannot take effect yet, so it is dropped and the requester re-asserts.
   // An exception in the same cycle always wins over the branch.
   // -------------------------------------------------------------------------
   always_comb begin
      int lim;
      br_hit  = bus.br_flush_req && !bus.exc_req &&
                !(stall_any && (bus.br_stage <= stall_b));
      lim     = bus.br_delayslot ? int'(bus.br_stage) - 1 : int'(bus.br_stage);
      br_mask = '0;
      for (int k = 0; k < STAGES; k++) begin
         br_mask[k] = (k < lim);
      end
   end

   // -------------------------------------------------------------------------
   // Exception FSM: next state and controls.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      refill_d   = refill_q;
      stall_o    = '0;
      flush_o    = '0;
      pc_stall_o = bus.fetch_full;
      redirect_o = 1'b0;

      // Normal-operation controls shared by IDLE and RECOVER; flush wins over
      // stall on any stage that both would touch.
      flush_o = merge_bubble | (br_hit ? br_mask : '0);
      stall_o = merge_stall & ~flush_o;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.exc_req) begin
               stall_o = '1;
               flush_o = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            stall_o    = '1;
            flush_o    = '0;
            pc_stall_o = 1'b1;
            if (!bus.exc_hold) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            stall_o    = '0;
            flush_o    = '1;
            redirect_o = 1'b1;
            if (REFILL == 0) begin
               state_d = ST_IDLE;
            end else begin
               state_d  = ST_RECOVER;
               refill_d = RF_W'(REFILL);
            end
         end
         ST_RECOVER: begin
            pc_stall_o = 1'b1;
            if (refill_q <= RF_W'(1)) begin
               state_d  = ST_IDLE;
               refill_d = '0;
            end else begin
               refill_d = refill_q - RF_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Saturating performance counters; clear wins over increment.
   // -------------------------------------------------------------------------
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (bus.cnt_clr) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall_o[0] && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
         if ((|flush_o) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         refill_q    <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         refill_q    <= refill_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Controls are combinational, so they are gated directly by rst to be
   // quiet for the whole reset window rather than from the next edge on.
   assign bus.stage_stall  = rst ? '0 : stall_o;
   assign bus.stage_flush  = rst ? '0 : flush_o;
   assign bus.pc_stall     = rst ? 1'b0 : pc_stall_o;
   assign bus.exc_redirect = rst ? 1'b0 : redirect_o;
   assign bus.exc_busy     = !rst && (state_q != ST_IDLE);
   assign bus.stall_cnt    = stall_cnt_q;
   assign bus.flush_cnt    = flush_cnt_q;
   assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_fsm
//   Bench for pipe_ctrl_fsm (STAGES=6, STALL_SRC=4, IDX_W=3, REFILL=2,
//   CNT_W=4). Inputs change 1 time unit after each rising edge; the expected
//   outputs for that cycle are pushed into exp_q at the same time and a
//   monitor pops and compares them on the following falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl_fsm;
   localparam int STAGES    = 6;
   localparam int STALL_SRC = 4;
   localparam int IDX_W     = 3;
   localparam int REFILL    = 2;
   localparam int CNT_W     = 4;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [STAGES-1:0] st;
      logic [STAGES-1:0] fl;
      logic              pc;
      logic              red;
      logic              busy;
      logic [CNT_W-1:0]  sc;
      logic [CNT_W-1:0]  fc;
   } exp_t;
   localparam int EW = $bits(exp_t);

   logic clk;
   logic rst;
   pipe_ctrl_if #(.STAGES(STAGES), .STALL_SRC(STALL_SRC), .IDX_W(IDX_W),
                  .CNT_W(CNT_W)) bus ();

   pipe_ctrl_fsm #(.STAGES(STAGES), .STALL_SRC(STALL_SRC), .IDX_W(IDX_W),
                   .REFILL(REFILL), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- staged stimulus ----------------
   logic                 n_rst;
   logic [STALL_SRC-1:0] n_req;
   int                   n_b [STALL_SRC];
   logic                 n_ff, n_br, n_ds, n_exc, n_hold, n_clr;
   int                   n_d;

   // ---------------- reference model state ----------------
   // Exception progress kept as "still waiting", "flush due now" and
   // "refill cycles left"; idle means none of these are pending.
   bit  m_waiting;
   bit  m_flush_due;
   int  m_refill_left;
   int  m_stall_cnt;
   int  m_flush_cnt;

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int n_tests;
   int n_fail;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_t'(exp_q.pop_front());
         check("stage_stall",  32'(bus.stage_stall),  32'(e.st));
         check("stage_flush",  32'(bus.stage_flush),  32'(e.fl));
         check("pc_stall",     32'(bus.pc_stall),     32'(e.pc));
         check("exc_redirect", 32'(bus.exc_redirect), 32'(e.red));
         check("exc_busy",     32'(bus.exc_busy),     32'(e.busy));
         check("stall_cnt",    32'(bus.stall_cnt),    32'(e.sc));
         check("flush_cnt",    32'(bus.flush_cnt),    32'(e.fc));
      end
   end

   // Expected outputs for the current inputs, then advance the model.
   task automatic model_push();
      exp_t e;
      int   bmax;
      int   lim;
      bit   idle;
      e = '0;
      if (n_rst) begin
         m_waiting = 0; m_flush_due = 0; m_refill_left = 0;
         m_stall_cnt = 0; m_flush_cnt = 0;
         exp_q.push_back(EW'(e));
         return;
      end
      idle   = !m_waiting && !m_flush_due && (m_refill_left == 0);
      e.busy = !idle;
      e.sc   = CNT_W'(m_stall_cnt);
      e.fc   = CNT_W'(m_flush_cnt);
      e.pc   = n_ff;
      if (idle && n_exc) begin
         e.st = '1;
         m_waiting = 1;
      end else if (m_waiting) begin
         e.st = '1;
         e.pc = 1'b1;
         if (!n_hold) begin
            m_waiting = 0;
            m_flush_due = 1;
         end
      end else if (m_flush_due) begin
         e.fl  = '1;
         e.red = 1'b1;
         m_flush_due = 0;
         m_refill_left = REFILL;
      end else begin
         bmax = -1;
         for (int i = 0; i < STALL_SRC; i++)
            if (n_req[i] && n_b[i] > bmax) bmax = n_b[i];
         for (int k = 0; k < STAGES; k++) begin
            if (k <= bmax) e.st[k] = 1'b1;
            if (bmax >= 0 && k == bmax + 1) e.fl[k] = 1'b1;
         end
         if (n_br && !n_exc && !(bmax >= 0 && n_d <= bmax)) begin
            lim = n_ds ? n_d - 1 : n_d;
            for (int k = 0; k < STAGES; k++)
               if (k < lim) e.fl[k] = 1'b1;
         end
         e.st = e.st & ~e.fl;
         if (m_refill_left > 0) begin
            e.pc = 1'b1;
            m_refill_left--;
         end
      end
      if (n_clr) begin
         m_stall_cnt = 0;
         m_flush_cnt = 0;
      end else begin
         if (e.st[0] && m_stall_cnt < CNT_MAX) m_stall_cnt++;
         if (|e.fl && m_flush_cnt < CNT_MAX) m_flush_cnt++;
      end
      exp_q.push_back(EW'(e));
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      n_rst = 0; n_req = '0; n_ff = 0; n_br = 0; n_ds = 0; n_d = 0;
      n_exc = 0; n_hold = 0; n_clr = 0;
      for (int i = 0; i < STALL_SRC; i++) n_b[i] = 0;
   endtask

   task automatic apply();
      @(posedge clk);
      #1;
      rst = n_rst;
      bus.stall_req = n_req;
      for (int i = 0; i < STALL_SRC; i++)
         bus.stall_stage[i*IDX_W +: IDX_W] = IDX_W'(n_b[i]);
      bus.fetch_full   = n_ff;
      bus.br_flush_req = n_br;
      bus.br_stage     = IDX_W'(n_d);
      bus.br_delayslot = n_ds;
      bus.exc_req      = n_exc;
      bus.exc_hold     = n_hold;
      bus.cnt_clr      = n_clr;
      model_push();
      n_exc = 0;  // exception request is a one-cycle pulse
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) apply();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      bus.stall_req = '0; bus.stall_stage = '0; bus.fetch_full = 0;
      bus.br_flush_req = 0; bus.br_stage = '0; bus.br_delayslot = 0;
      bus.exc_req = 0; bus.exc_hold = 0; bus.cnt_clr = 0;
      clear_inputs();

      // Reset
      n_rst = 1;
      idle_cycles(3);
      n_rst = 0;
      idle_cycles(1);

      // Stall merge: one source at b=2, then a second at b=4
      n_req = 4'b0001; n_b[0] = 2;
      apply();
      n_req = 4'b0011; n_b[1] = 4;
      apply();
      n_req = 4'b0010; n_b[1] = 5;   // deepest boundary: no bubble
      apply();
      clear_inputs();

      // Branch flush: plain, with delay slot, suppressed by stall, edge cases
      n_br = 1; n_d = 3;
      apply();
      n_ds = 1;
      apply();
      n_ds = 0; n_req = 4'b0001; n_b[0] = 3;
      apply();
      n_b[0] = 1; n_d = 4; n_ds = 1;  // stall shallower than branch
      apply();
      clear_inputs();
      n_br = 1; n_d = 0;
      apply();
      n_d = 1; n_ds = 1;
      apply();
      clear_inputs();

      // Exception with exc_hold for 3 cycles, second exc_req in WAIT
      n_exc = 1; n_hold = 1;
      apply();
      n_exc = 1;
      apply();
      apply();
      n_hold = 0;
      idle_cycles(6);

      // Exception and branch in the same cycle, fetch_full during FLUSH
      n_exc = 1; n_br = 1; n_d = 4;
      apply();
      n_br = 0; n_ff = 1;
      idle_cycles(5);
      clear_inputs();

      // Counter saturation and clear
      n_req = 4'b0100; n_b[2] = 1;
      idle_cycles(20);
      n_clr = 1;
      apply();
      n_clr = 0;
      idle_cycles(2);
      clear_inputs();

      // Reset while waiting on exc_hold
      n_exc = 1; n_hold = 1;
      idle_cycles(2);
      n_rst = 1;
      idle_cycles(2);
      n_rst = 0; n_hold = 0;
      idle_cycles(3);

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < STALL_SRC; i++) begin
            n_req[i] = ($urandom_range(0, 3) == 0);
            n_b[i]   = $urandom_range(0, STAGES - 1);
         end
         n_ff   = ($urandom_range(0, 3) == 0);
         n_br   = ($urandom_range(0, 3) == 0);
         n_d    = $urandom_range(0, (1 << IDX_W) - 1);
         n_ds   = $urandom_range(0, 1);
         n_exc  = ($urandom_range(0, 15) == 0);
         n_hold = ($urandom_range(0, 1) == 1);
         n_clr  = ($urandom_range(0, 49) == 0);
         n_rst  = ($urandom_range(0, 199) == 0);
         apply();
      end
      clear_inputs();
      idle_cycles(4);

      // Drain: monitor must have consumed every expectation
      repeat (3) @(posedge clk);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
